// File: rtl/fft_pkg.sv
// Shared FFT definitions: transform size, sample format, start-pulse length and the
// sample-loader state encoding. Imported by the loader, its stream interface, the
// result checker and the top level.
package fft_pkg;

  localparam int unsigned N_POINTS  = 32;
  localparam int unsigned ADDR_W    = $clog2(N_POINTS);
  // [63:32] real, [31:0] imaginary, two's complement
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned START_LEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitLo,
    StWaitHi
  } loader_state_t;

endpackage

// File: rtl/fft_sample_loader_if.sv
// Sample stream into the FFT loader.
//   s_valid : source has a sample
//   s_data  : complex sample, DATA_W bits
//   s_last  : final sample of the frame
//   s_ready : loader accepts the sample this cycle
// master = sample source, slave = loader.
interface fft_sample_loader_if;
  import fft_pkg::*;

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/bit_reverse.sv
// Combinational bit reversal of a W-bit value (bit i of the output is bit W-1-i of the
// input). Used to form radix-2 DIT input addresses.
//   value_i : value to reverse
//   value_o : reversed value
module bit_reverse #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] value_i,
  output logic [W-1:0] value_o
);

  always_comb begin
    value_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      value_o[i] = value_i[W-1-i];
    end
  end

endmodule

// File: rtl/fft_sample_loader.sv
// FFT sample loader: after an arm request, accepts N_POINTS samples from the stream,
// writes each into FFT working memory at the bit-reversed sample index, pulses start_fft
// for START_LEN cycles, then waits for the core's done level to fall and rise again.
//   clk, rst_n : clock, synchronous active-low reset
//   arm        : begin a load frame (honoured only when idle)
//   stream     : sample stream (slave side)
//   mem_we / mem_addr / mem_wdata : registered FFT memory write port
//   start_fft  : start pulse to the FFT core
//   fft_done   : core done level, low while running
//   busy       : loader not idle
//   frame_done : one-cycle pulse when the FFT of a loaded frame completes
//   len_err    : sticky frame-length error, cleared by the next accepted arm
module fft_sample_loader
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  fft_sample_loader_if.slave  stream,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                start_fft,
  input  logic                fft_done,
  output logic                busy,
  output logic                frame_done,
  output logic                len_err
);

  localparam int unsigned StartCntW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [ADDR_W-1:0]    LastCnt   = ADDR_W'(N_POINTS - 1);
  localparam logic [StartCntW-1:0] StartLast = StartCntW'(START_LEN - 1);

  loader_state_t          state_q;
  logic [ADDR_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]      cnt_rev;
  logic [StartCntW-1:0]   st_cnt_q;
  logic                   mem_we_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic                   start_fft_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic                   len_err_q;
  logic                   accept;

  // Ready straight from state so back-to-back beats flow at full rate.
  assign stream.s_ready = (state_q == StLoad);
  assign accept         = stream.s_valid & stream.s_ready;

  bit_reverse #(
    .W (ADDR_W)
  ) u_bit_reverse (
    .value_i (cnt_q),
    .value_o (cnt_rev)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      st_cnt_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      start_fft_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy drops here, one cycle after the frame_done pulse
          busy_q <= arm;
          if (arm) begin
            state_q   <= StLoad;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
          end
        end
        StLoad: begin
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cnt_rev;
            mem_wdata_q <= stream.s_data;
            cnt_q       <= cnt_q + ADDR_W'(1);
            if (cnt_q == LastCnt) begin
              // Start goes out together with the last write.
              state_q     <= StStart;
              start_fft_q <= 1'b1;
              st_cnt_q    <= '0;
              if (!stream.s_last) len_err_q <= 1'b1;
            end else if (stream.s_last) begin
              // Short frame: keep the beat written but never start the core.
              len_err_q <= 1'b1;
              state_q   <= StIdle;
              busy_q    <= 1'b0;
            end
          end
        end
        StStart: begin
          if (st_cnt_q == StartLast) begin
            start_fft_q <= 1'b0;
            state_q     <= StWaitLo;
          end else begin
            st_cnt_q <= st_cnt_q + StartCntW'(1);
          end
        end
        StWaitLo: begin
          if (!fft_done) state_q <= StWaitHi;
        end
        StWaitHi: begin
          if (fft_done) begin
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign start_fft  = start_fft_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: random and directed frames, a scoreboard of
// expected memory writes, start pulses and frame completions, and a simple FFT core model.
module tb_fft_sample_loader;
  import fft_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              fft_done = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              start_fft;
  logic              busy;
  logic              frame_done;
  logic              len_err;

  fft_sample_loader_if sif ();

  fft_sample_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .stream     (sif),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .start_fft  (start_fft),
    .fft_done   (fft_done),
    .busy       (busy),
    .frame_done (frame_done),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  int starts_pending = 0;
  int dones_pending = 0;
  int done_count = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int last_wr_cyc = -100;
  int rise_cyc = -100;
  int start_run = 0;
  bit prev_fd = 1'b0;
  logic prev_fft_done = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference bit reversal by repeated halving.
  function automatic logic [ADDR_W-1:0] ref_rev(input int k);
    int v = k;
    int r = 0;
    for (int i = 0; i < int'(ADDR_W); i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return ADDR_W'(r);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0h data %0h, none expected",
                   mem_addr, mem_wdata);
        end else begin
          logic [ADDR_W-1:0] ea;
          logic [DATA_W-1:0] ed;
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(ea));
          check("wr_data", mem_wdata, ed);
        end
        last_wr_cyc = cyc;
      end
      if (start_fft === 1'b1) begin
        if (start_run == 0) begin
          check("start_expected", 64'(starts_pending > 0), 64'(1));
          if (starts_pending > 0) starts_pending--;
          check("start_after_writes", 64'(exp_addr_q.size()), 64'(0));
          check("start_align_last_write", 64'(cyc - last_wr_cyc), 64'(0));
        end
        start_run++;
      end else if (start_run != 0) begin
        check("start_len", 64'(start_run), 64'(START_LEN));
        start_run = 0;
      end
      if (fft_done === 1'b1 && prev_fft_done === 1'b0) rise_cyc = cyc;
      prev_fft_done = fft_done;
      if (frame_done === 1'b1) begin
        check("done_expected", 64'(dones_pending > 0), 64'(1));
        if (dones_pending > 0) dones_pending--;
        check("done_timing", 64'(cyc - rise_cyc), 64'(1));
        check("busy_at_done", 64'(busy), 64'(1));
        check("done_single_cycle", 64'(prev_fd), 64'(0));
        done_count++;
      end
      prev_fd = (frame_done === 1'b1);
    end
  end

  // FFT core model: done falls 3 cycles after start, rises 40 cycles later.
  initial begin
    forever begin
      @(posedge start_fft);
      repeat (3) @(posedge clk);
      #1 fft_done = 1'b0;
      repeat (40) @(posedge clk);
      #1 fft_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, output bit ok);
    int guard = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    while (sif.s_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    ok = (sif.s_ready === 1'b1);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: s_ready got %b required 1 within 50 cycles", sif.s_ready);
    end else begin
      tick();
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  // Sends up to n beats; s_last on beat last_pos. Stops after an early s_last.
  task automatic send_frame(input int n, input int last_pos, input bit gaps, input bit ramp);
    bit ok;
    logic [DATA_W-1:0] d;
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0) tick();
      d = ramp ? DATA_W'(k) : {$urandom, $urandom};
      send_beat(d, k == last_pos, ok);
      if (!ok) return;
      exp_addr_q.push_back(ref_rev(k));
      exp_data_q.push_back(d);
      if (k == int'(N_POINTS) - 1) begin
        starts_pending++;
        dones_pending++;
      end
      if (k == last_pos && k < int'(N_POINTS) - 1) return;
    end
  endtask

  task automatic wait_frame_done(input bit poke_arm);
    int base = done_count;
    int guard = 0;
    if (poke_arm) begin
      while (fft_done !== 1'b0 && guard < 100) begin
        tick();
        guard++;
      end
      repeat (10) tick();
      do_arm();  // lands in WAIT_HI and must be ignored
    end
    guard = 0;
    while (done_count == base && guard < 400) begin
      tick();
      guard++;
    end
    check("frame_done_seen", 64'(done_count > base), 64'(1));
    check("idle_after_done_busy", 64'(busy), 64'(0));
    check("idle_after_done_ready", 64'(sif.s_ready), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 64'(sif.s_ready), 64'(0));
    check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, mem_wdata, 64'(0));
    check({tag, "_start_fft"}, 64'(start_fft), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    check({tag, "_len_err"}, 64'(len_err), 64'(0));
  endtask

  initial begin
    int lp;
    bit gp;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a load
    do_arm();
    check("arm_busy", 64'(busy), 64'(1));
    check("arm_ready", 64'(sif.s_ready), 64'(1));
    send_frame(10, 99, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check_all_zero("midload_reset");
    rst_n = 1'b1;
    tick();

    // Ramp data, back-to-back, arm poked during WAIT_HI
    do_arm();
    send_frame(int'(N_POINTS), int'(N_POINTS) - 1, 1'b0, 1'b1);
    check("ramp_len_err", 64'(len_err), 64'(0));
    wait_frame_done(1'b1);
    check("ramp_len_err_after", 64'(len_err), 64'(0));

    // s_valid toggled every other cycle
    do_arm();
    send_frame(int'(N_POINTS), int'(N_POINTS) - 1, 1'b1, 1'b0);
    wait_frame_done(1'b0);
    check("gap_len_err", 64'(len_err), 64'(0));

    // Early s_last on beat 20
    do_arm();
    send_frame(int'(N_POINTS), 20, 1'b0, 1'b0);
    check("short_len_err", 64'(len_err), 64'(1));
    check("short_busy", 64'(busy), 64'(0));
    check("short_ready", 64'(sif.s_ready), 64'(0));
    repeat (6) tick();
    do_arm();
    check("rearm_clears_len_err", 64'(len_err), 64'(0));
    send_frame(int'(N_POINTS), int'(N_POINTS) - 1, 1'b0, 1'b0);
    wait_frame_done(1'b0);

    // Full frame without s_last
    do_arm();
    send_frame(int'(N_POINTS), 99, 1'b0, 1'b0);
    check("nolast_len_err", 64'(len_err), 64'(1));
    wait_frame_done(1'b0);
    check("nolast_len_err_sticky", 64'(len_err), 64'(1));

    // Random frames
    for (int f = 0; f < 6; f++) begin
      lp = int'($urandom_range(0, 40));
      gp = 1'($urandom_range(0, 1));
      do_arm();
      send_frame(int'(N_POINTS), lp, gp, 1'b0);
      check("rand_len_err", 64'(len_err), 64'(lp != int'(N_POINTS) - 1));
      if (lp < int'(N_POINTS) - 1) begin
        check("rand_short_busy", 64'(busy), 64'(0));
        repeat (4) tick();
      end else begin
        wait_frame_done(1'b0);
      end
    end

    repeat (8) tick();
    check("writes_drained", 64'(exp_addr_q.size()), 64'(0));
    check("starts_drained", 64'(starts_pending), 64'(0));
    check("dones_drained", 64'(dones_pending), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
